// File: rtl/alu_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_div_unit
//  Description : Iterative RV32M divider (DIV/DIVU/REM/REMU). Restoring
//                radix-2 algorithm producing one quotient bit per clock.
//                Divide-by-zero and signed overflow finish on a fast path
//                one cycle after accept.
//  Ports       : clk          - clock, rising edge
//                rst          - asynchronous active-high reset
//                div_in1_i    - dividend (rs1)
//                div_in2_i    - divisor (rs2)
//                div_op_i     - 00=DIV 01=DIVU 10=REM 11=REMU
//                div_valid_i  - request valid, sampled with div_ready_o
//                div_ready_o  - high only while idle
//                div_out_o    - result, stable from done until next accept
//                div_done_o   - one-cycle result-valid pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_div_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] div_in1_i,
   input  logic [XLEN-1:0] div_in2_i,
   input  logic [1:0]      div_op_i,
   input  logic            div_valid_i,
   output logic            div_ready_o,
   output logic [XLEN-1:0] div_out_o,
   output logic            div_done_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   quo_q, quo_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   dvsr_q, dvsr_d;
   logic [XLEN-1:0]   out_q, out_d;
   logic              q_neg_q, q_neg_d;
   logic              r_neg_q, r_neg_d;
   logic              sel_rem_q, sel_rem_d;

   // Operand conditioning at accept
   logic              is_signed, sign1, sign2, div_zero, ovf;
   logic [XLEN-1:0]   mag1, mag2, fast_res;

   // One restoring iteration
   logic [XLEN:0]     rem_sh, trial;
   logic              ge;
   logic [XLEN-1:0]   rem_step, quo_step, quo_fix, rem_fix, final_res;

   always_comb begin
      is_signed = ~div_op_i[0];
      sign1     = is_signed & div_in1_i[XLEN-1];
      sign2     = is_signed & div_in2_i[XLEN-1];
      mag1      = sign1 ? -div_in1_i : div_in1_i;
      mag2      = sign2 ? -div_in2_i : div_in2_i;
      div_zero  = (div_in2_i == '0);
      ovf       = is_signed && (div_in1_i == C_INT_MIN) && (div_in2_i == '1);
      // Zero divisor takes precedence: remainder is the raw dividend.
      if (div_zero)
         fast_res = div_op_i[1] ? div_in1_i : '1;
      else
         fast_res = div_op_i[1] ? '0 : C_INT_MIN;
   end

   always_comb begin
      // Shift at XLEN+1 bits so the partial remainder never loses its MSB
      // when the divisor magnitude exceeds 2**(XLEN-1).
      rem_sh    = {rem_q, quo_q[XLEN-1]};
      trial     = rem_sh - {1'b0, dvsr_q};
      ge        = ~trial[XLEN];
      rem_step  = ge ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
      quo_step  = {quo_q[XLEN-2:0], ge};
      quo_fix   = q_neg_q ? -quo_step : quo_step;
      rem_fix   = r_neg_q ? -rem_step : rem_step;
      final_res = sel_rem_q ? rem_fix : quo_fix;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvsr_d    = dvsr_q;
      out_d     = out_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      sel_rem_d = sel_rem_q;
      case (state_q)
         S_IDLE: begin
            if (div_valid_i) begin
               sel_rem_d = div_op_i[1];
               q_neg_d   = sign1 ^ sign2;
               r_neg_d   = sign1;
               if (div_zero || ovf) begin
                  out_d   = fast_res;
                  state_d = S_DONE;
               end else begin
                  quo_d   = mag1;
                  rem_d   = '0;
                  dvsr_d  = mag2;
                  cnt_d   = CNT_W'(XLEN - 1);
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            quo_d = quo_step;
            rem_d = rem_step;
            if (cnt_q == '0) begin
               out_d   = final_res;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvsr_q    <= '0;
         out_q     <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         sel_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvsr_q    <= dvsr_d;
         out_q     <= out_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         sel_rem_q <= sel_rem_d;
      end
   end

   // All outputs come straight from registers.
   assign div_ready_o = (state_q == S_IDLE);
   assign div_done_o  = (state_q == S_DONE);
   assign div_out_o   = out_q;

endmodule
`default_nettype wire
